// File: rtl/gp_regfile_if.sv
// gp_regfile_if: register-file bus between the decoder/control unit (master)
// and the register file (slave). Carries the writeback port, the two operand
// read ports, the issue port and the scoreboard/hazard outputs.
interface gp_regfile_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_dest;
    logic [NUM_REGS-1:0]   pending;
    logic                  hazard_a;
    logic                  hazard_b;

    modport master (
        output write_enable, write_addr, write_data,
        output read_addr_a, read_addr_b,
        output issue_valid, issue_dest,
        input  read_data_a, read_data_b,
        input  pending, hazard_a, hazard_b
    );

    modport slave (
        input  write_enable, write_addr, write_data,
        input  read_addr_a, read_addr_b,
        input  issue_valid, issue_dest,
        output read_data_a, read_data_b,
        output pending, hazard_a, hazard_b
    );
endinterface

// File: rtl/gp_regfile.sv
// gp_regfile: NUM_REGS x DATA_WIDTH register file for the VR16 datapath.
// One synchronous write port, two combinational read ports with same-cycle
// write bypass, and a per-register pending scoreboard that reports
// read-after-write hazards to the control unit.
// Optional build macro GP_REGFILE_ZERO_REG_EN: register 0 reads as zero,
// ignores writes and never becomes pending.
module gp_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    gp_regfile_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

`ifdef GP_REGFILE_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;

    logic                  wr_ok_s;
    logic [DATA_WIDTH-1:0] rd_a_s;
    logic [DATA_WIDTH-1:0] rd_b_s;
    logic                  hz_a_s;
    logic                  hz_b_s;

    // Qualify the write: with a hardwired zero register, address 0 writes are dropped.
    always_comb begin
        wr_ok_s = bus.write_enable;
        if (ZERO_REG && (bus.write_addr == {ADDR_WIDTH{1'b0}})) begin
            wr_ok_s = 1'b0;
        end else begin
            wr_ok_s = bus.write_enable;
        end
    end

    // Next-state of register array and scoreboard; a new issue beats a same-cycle writeback.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (wr_ok_s) begin
            regs_d[bus.write_addr] = bus.write_data;
        end else begin
            regs_d[bus.write_addr] = regs_q[bus.write_addr];
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.issue_valid && (bus.issue_dest == ADDR_WIDTH'(i))
                && !(ZERO_REG && (i == 0))) begin
                pending_d[i] = 1'b1;
            end else if (wr_ok_s && (bus.write_addr == ADDR_WIDTH'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // State registers with synchronous active-high reset that discards in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
            pending_q <= {NUM_REGS{1'b0}};
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    // Operand A read with writeback bypass and hazard flag.
    always_comb begin
        rd_a_s = regs_q[bus.read_addr_a];
        hz_a_s = pending_q[bus.read_addr_a];
        if (ZERO_REG && (bus.read_addr_a == {ADDR_WIDTH{1'b0}})) begin
            rd_a_s = {DATA_WIDTH{1'b0}};
            hz_a_s = 1'b0;
        end else if (bus.write_enable && (bus.write_addr == bus.read_addr_a)) begin
            rd_a_s = bus.write_data;
            hz_a_s = 1'b0;
        end else begin
            rd_a_s = regs_q[bus.read_addr_a];
            hz_a_s = pending_q[bus.read_addr_a];
        end
    end

    // Operand B read with writeback bypass and hazard flag.
    always_comb begin
        rd_b_s = regs_q[bus.read_addr_b];
        hz_b_s = pending_q[bus.read_addr_b];
        if (ZERO_REG && (bus.read_addr_b == {ADDR_WIDTH{1'b0}})) begin
            rd_b_s = {DATA_WIDTH{1'b0}};
            hz_b_s = 1'b0;
        end else if (bus.write_enable && (bus.write_addr == bus.read_addr_b)) begin
            rd_b_s = bus.write_data;
            hz_b_s = 1'b0;
        end else begin
            rd_b_s = regs_q[bus.read_addr_b];
            hz_b_s = pending_q[bus.read_addr_b];
        end
    end

    assign bus.read_data_a = rd_a_s;
    assign bus.read_data_b = rd_b_s;
    assign bus.hazard_a    = hz_a_s;
    assign bus.hazard_b    = hz_b_s;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_gp_regfile.sv
// tb_gp_regfile: directed vector table for the documented scenarios, then
// randomized traffic checked against an array-based reference model.
module tb_gp_regfile;
    localparam int DW = 16;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    gp_regfile_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    gp_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        iv;
        logic [2:0]  id;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ha;
        logic        hb;
        logic [7:0]  ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic chk, logic rst, logic we, logic [2:0] wa,
                                logic [15:0] wd, logic [2:0] ra, logic [2:0] rb,
                                logic iv, logic [2:0] id, logic [15:0] ea,
                                logic [15:0] eb, logic ha, logic hb, logic [7:0] ep);
        vec_t v;
        v.chk = chk; v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
        v.ra = ra; v.rb = rb; v.iv = iv; v.id = id;
        v.ea = ea; v.eb = eb; v.ha = ha; v.hb = hb; v.ep = ep;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic we, logic [2:0] wa, logic [15:0] wd,
                         logic [2:0] ra, logic [2:0] rb, logic iv, logic [2:0] id);
        reset            = rst;
        bus.write_enable = we;
        bus.write_addr   = wa;
        bus.write_data   = wd;
        bus.read_addr_a  = ra;
        bus.read_addr_b  = rb;
        bus.issue_valid  = iv;
        bus.issue_dest   = id;
    endtask

    // Reference model state
    logic [15:0] m_regs [NR];
    bit          m_pend [NR];

    function automatic bit is_zero_reg(int a);
`ifdef GP_REGFILE_ZERO_REG_EN
        return a == 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] m_read(logic we, int wa, logic [15:0] wd, int ra);
        if (is_zero_reg(ra)) return 16'h0000;
        if (we && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    function automatic logic m_hazard(logic we, int wa, int ra);
        if (is_zero_reg(ra)) return 1'b0;
        return m_pend[ra] && !(we && wa == ra);
    endfunction

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] p;
        for (int i = 0; i < NR; i++) p[i] = m_pend[i];
        return p;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0);

        //            chk   rst   we    wa    wd        ra    rb    iv    id    ea        eb        ha    hb    ep
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd3, 16'h1111, 3'd3, 3'd4, 1'b0, 3'd0, 16'h1111, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd6, 1'b0, 3'd0, 16'h1111, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd5, 16'hABCD, 3'd5, 3'd5, 1'b0, 3'd0, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 1'b1, 3'd2, 16'hABCD, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 1'b0, 3'd0, 16'h1111, 16'h0000, 1'b0, 1'b1, 8'h04));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd2, 16'h0042, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0042, 16'h0042, 1'b0, 1'b0, 8'h04));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0042, 16'hABCD, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0, 1'b1, 3'd4, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd4, 1'b1, 3'd4, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 8'h10));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'h1111, 1'b1, 1'b0, 8'h10));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd1, 1'b1, 3'd1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 8'h10));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0042, 1'b1, 1'b0, 8'h02));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 3'd1, 16'hFFFF, 3'd1, 3'd2, 1'b0, 3'd0, 16'hFFFF, 16'h0042, 1'b0, 1'b1, 8'h06));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd4, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00));

        // Directed table: inputs applied after the edge, outputs sampled mid-cycle.
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            drive(tbl[k].rst, tbl[k].we, tbl[k].wa, tbl[k].wd,
                  tbl[k].ra, tbl[k].rb, tbl[k].iv, tbl[k].id);
            #2;
            if (tbl[k].chk) begin
                check($sformatf("tbl%0d read_data_a", k), 32'(bus.read_data_a), 32'(tbl[k].ea));
                check($sformatf("tbl%0d read_data_b", k), 32'(bus.read_data_b), 32'(tbl[k].eb));
                check($sformatf("tbl%0d hazard_a", k),    32'(bus.hazard_a),    32'(tbl[k].ha));
                check($sformatf("tbl%0d hazard_b", k),    32'(bus.hazard_b),    32'(tbl[k].hb));
                check($sformatf("tbl%0d pending", k),     32'(bus.pending),     32'(tbl[k].ep));
            end
        end

`ifdef GP_REGFILE_ZERO_REG_EN
        // Hardwired zero register: write and issue to address 0 have no effect.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 1'b1, 3'd0);
        #2;
        check("zr bypass read_data_a", 32'(bus.read_data_a), 32'h0);
        check("zr bypass read_data_b", 32'(bus.read_data_b), 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0);
        #2;
        check("zr read_data_a", 32'(bus.read_data_a), 32'h0);
        check("zr pending", 32'(bus.pending), 32'h0);
        check("zr hazard_a", 32'(bus.hazard_a), 32'h0);
`endif

        // Model starts from the state left by the table: everything zero.
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 16'h0000;
            m_pend[i] = 1'b0;
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic        rst, we, iv;
            int          wa, ra, rb, id;
            logic [15:0] wd;
            rst = ($urandom_range(0, 31) == 0);
            we  = $urandom_range(0, 1);
            iv  = $urandom_range(0, 1);
            wa  = $urandom_range(0, NR - 1);
            ra  = $urandom_range(0, NR - 1);
            rb  = $urandom_range(0, NR - 1);
            id  = $urandom_range(0, NR - 1);
            wd  = 16'($urandom);
            @(posedge clk); #1;
            drive(rst, we, 3'(wa), wd, 3'(ra), 3'(rb), iv, 3'(id));
            #2;
            check($sformatf("rnd%0d read_data_a", n), 32'(bus.read_data_a), 32'(m_read(we, wa, wd, ra)));
            check($sformatf("rnd%0d read_data_b", n), 32'(bus.read_data_b), 32'(m_read(we, wa, wd, rb)));
            check($sformatf("rnd%0d hazard_a", n),    32'(bus.hazard_a),    32'(m_hazard(we, wa, ra)));
            check($sformatf("rnd%0d hazard_b", n),    32'(bus.hazard_b),    32'(m_hazard(we, wa, rb)));
            check($sformatf("rnd%0d pending", n),     32'(bus.pending),     32'(m_pend_vec()));
            // Model update for the coming edge: writeback clears, then a new issue sets.
            if (rst) begin
                for (int i = 0; i < NR; i++) begin
                    m_regs[i] = 16'h0000;
                    m_pend[i] = 1'b0;
                end
            end else begin
                if (we && !is_zero_reg(wa)) begin
                    m_regs[wa] = wd;
                    m_pend[wa] = 1'b0;
                end
                if (iv && !is_zero_reg(id)) m_pend[id] = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
